cdp1802_cycle_sched: RTL and testbench

Machine-cycle sequencer and request arbiter for the cdp1802 core. Divides CLOCK into fixed-length machine cycles, generates the TPA/TPB timing pulses, and drives the state code SC. At each cycle boundary it decides whether the next cycle is Fetch (S0), Execute (S1), DMA (S2) or Interrupt (S3), arbitrating DMA-in, DMA-out and interrupt requests. The core commits on cycle_end and follows SC/grant outputs.

---
 rtl/cdp1802_pkg.sv | 17 +
 rtl/cdp1802_cycle_sched_if.sv | 31 +++
 rtl/cdp1802_tp_gen.sv | 41 ++++
 rtl/cdp1802_cycle_sched.sv | 103 ++++++++++
 tb/tb_cdp1802_cycle_sched.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cdp1802_pkg.sv
// Shared state-code constants and grant encoding for the cdp1802 core and its
// machine-cycle scheduler.
package cdp1802_pkg;

    localparam logic [1:0] SC_FETCH = 2'b00;
    localparam logic [1:0] SC_EXEC  = 2'b01;
    localparam logic [1:0] SC_DMA   = 2'b10;
    localparam logic [1:0] SC_INT   = 2'b11;

    typedef enum logic [1:0] {
        GNT_NONE    = 2'b00,
        GNT_DMA_IN  = 2'b01,
        GNT_DMA_OUT = 2'b10,
        GNT_INT     = 2'b11
    } grant_e;

endpackage

// File: rtl/cdp1802_cycle_sched_if.sv
// Request/timing bundle between the cdp1802 core and the cycle scheduler.
// master = scheduler side, slave = core side.
interface cdp1802_cycle_sched_if;

    logic       WAIT_N;
    logic       INT_N;
    logic       ie;
    logic       dma_in_req;
    logic       dma_out_req;
    logic       cpu_instr_end;
    logic       cpu_idle;
    logic [1:0] SC;
    logic       TPA;
    logic       TPB;
    logic       cycle_end;
    logic [3:0] cycle_cnt;
    logic       grant_dma_in;
    logic       grant_dma_out;
    logic       grant_int;

    modport master (
        input  WAIT_N, INT_N, ie, dma_in_req, dma_out_req, cpu_instr_end, cpu_idle,
        output SC, TPA, TPB, cycle_end, cycle_cnt, grant_dma_in, grant_dma_out, grant_int
    );

    modport slave (
        output WAIT_N, INT_N, ie, dma_in_req, dma_out_req, cpu_instr_end, cpu_idle,
        input  SC, TPA, TPB, cycle_end, cycle_cnt, grant_dma_in, grant_dma_out, grant_int
    );

endinterface

// File: rtl/cdp1802_tp_gen.sv
// Machine-cycle position counter with TPA/TPB pulses and end-of-cycle strobe.
module cdp1802_tp_gen #(
    parameter int CLKS_PER_CYCLE = 8,
    parameter int TPA_POS        = 1,
    parameter int TPB_POS        = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wait_n,
    output logic [3:0] cycle_cnt,
    output logic       tpa,
    output logic       tpb,
    output logic       cycle_end
);

    localparam logic [3:0] CNT_LAST = 4'(CLKS_PER_CYCLE - 1);
    localparam logic [3:0] CNT_TPA  = 4'(TPA_POS);
    localparam logic [3:0] CNT_TPB  = 4'(TPB_POS);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wait_n) begin
            cnt_d = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Pulses are gated by the live WAIT_N so a pause suppresses them at once.
    assign cycle_cnt = cnt_q;
    assign tpa       = wait_n && (cnt_q == CNT_TPA);
    assign tpb       = wait_n && (cnt_q == CNT_TPB);
    assign cycle_end = wait_n && (cnt_q == CNT_LAST);

endmodule

// File: rtl/cdp1802_cycle_sched.sv
// cdp1802 machine-cycle sequencer: picks S0/S1/S2/S3 at each cycle boundary.
// Optional build macro CDP1802_INT_LATCH_EN latches short INT_N pulses.
module cdp1802_cycle_sched
    import cdp1802_pkg::*;
#(
    parameter int CLKS_PER_CYCLE = 8,
    parameter int TPA_POS        = 1,
    parameter int TPB_POS        = 6
) (
    input logic                   CLOCK,
    input logic                   CLEAR_N,
    cdp1802_cycle_sched_if.master bus
);

    logic       cycle_end;
    logic [1:0] sc_q, sc_d;
    grant_e     grant_q, grant_d;
    logic       init_q, init_d;
    logic       boundary;
    logic       int_req;

    cdp1802_tp_gen #(
        .CLKS_PER_CYCLE (CLKS_PER_CYCLE),
        .TPA_POS        (TPA_POS),
        .TPB_POS        (TPB_POS)
    ) u_tp_gen (
        .clk       (CLOCK),
        .rst_n     (CLEAR_N),
        .wait_n    (bus.WAIT_N),
        .cycle_cnt (bus.cycle_cnt),
        .tpa       (bus.TPA),
        .tpb       (bus.TPB),
        .cycle_end (cycle_end)
    );

`ifdef CDP1802_INT_LATCH_EN
    logic int_pend_q, int_pend_d;
    assign int_req = int_pend_q;
`else
    assign int_req = !bus.INT_N;
`endif

    always_ff @(posedge CLOCK) begin
        if (!CLEAR_N) begin
            sc_q    <= SC_EXEC;
            grant_q <= GNT_NONE;
            init_q  <= 1'b1;
`ifdef CDP1802_INT_LATCH_EN
            int_pend_q <= 1'b0;
`endif
        end else begin
            sc_q    <= sc_d;
            grant_q <= grant_d;
            init_q  <= init_d;
`ifdef CDP1802_INT_LATCH_EN
            int_pend_q <= int_pend_d;
`endif
        end
    end

    always_comb begin
        sc_d     = sc_q;
        grant_d  = grant_q;
        init_d   = init_q;
        boundary = (sc_q == SC_DMA) || (sc_q == SC_INT) ||
                   ((sc_q == SC_EXEC) && (bus.cpu_instr_end || init_q || bus.cpu_idle));
        if (cycle_end) begin
            init_d  = 1'b0;
            grant_d = GNT_NONE;
            if (!boundary) begin
                sc_d = SC_EXEC;
            end else if (bus.dma_in_req) begin
                sc_d    = SC_DMA;
                grant_d = GNT_DMA_IN;
            end else if (bus.dma_out_req) begin
                sc_d    = SC_DMA;
                grant_d = GNT_DMA_OUT;
            end else if (int_req && bus.ie && (sc_q != SC_INT)) begin
                sc_d    = SC_INT;
                grant_d = GNT_INT;
            end else if (bus.cpu_idle && (sc_q == SC_EXEC)) begin
                sc_d = SC_EXEC;
            end else begin
                sc_d = SC_FETCH;
            end
        end
`ifdef CDP1802_INT_LATCH_EN
        // Clearing on grant wins over a same-clock set.
        int_pend_d = int_pend_q;
        if (bus.WAIT_N && !bus.INT_N) int_pend_d = 1'b1;
        if (cycle_end && (grant_d == GNT_INT)) int_pend_d = 1'b0;
`endif
    end

    always_comb begin
        bus.SC            = sc_q;
        bus.cycle_end     = cycle_end;
        bus.grant_dma_in  = (grant_q == GNT_DMA_IN);
        bus.grant_dma_out = (grant_q == GNT_DMA_OUT);
        bus.grant_int     = (grant_q == GNT_INT);
    end

endmodule

// File: tb/tb_cdp1802_cycle_sched.sv
// Self-checking bench for cdp1802_cycle_sched: directed test-plan steps then
// randomized traffic against a cycle-level reference model.
module tb_cdp1802_cycle_sched;

    logic CLOCK = 1'b0;
    logic CLEAR_N = 1'b0;
    always #5 CLOCK = ~CLOCK;

    cdp1802_cycle_sched_if bus();

    cdp1802_cycle_sched dut (
        .CLOCK   (CLOCK),
        .CLEAR_N (CLEAR_N),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: position within cycle, current cycle kind, who is served.
    int m_pos;
    int m_state;   // 0 fetch, 1 execute, 2 dma, 3 interrupt
    int m_served;  // 0 nobody, 1 dma-in, 2 dma-out, 3 interrupt
    bit m_first;
    bit m_pend;

    function automatic logic [11:0] observed();
        return {bus.SC, bus.TPA, bus.TPB, bus.cycle_end, bus.cycle_cnt,
                bus.grant_dma_in, bus.grant_dma_out, bus.grant_int};
    endfunction

    function automatic logic [11:0] expected();
        return {2'(m_state), bus.WAIT_N && (m_pos == 1), bus.WAIT_N && (m_pos == 6),
                bus.WAIT_N && (m_pos == 7), 4'(m_pos),
                m_served == 1, m_served == 2, m_served == 3};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit may_switch, wants_int, took_int;
        if (!CLEAR_N) begin
            m_pos = 0; m_state = 1; m_served = 0; m_first = 1; m_pend = 0;
            return;
        end
        if (!bus.WAIT_N) return;
        took_int = 0;
`ifdef CDP1802_INT_LATCH_EN
        wants_int = m_pend;
`else
        wants_int = !bus.INT_N;
`endif
        if (m_pos == 7) begin
            may_switch = (m_state >= 2) ||
                         (m_state == 1 && (bus.cpu_instr_end || m_first || bus.cpu_idle));
            m_served = 0;
            if (!may_switch)                                 m_state = 1;
            else if (bus.dma_in_req)  begin m_state = 2; m_served = 1; end
            else if (bus.dma_out_req) begin m_state = 2; m_served = 2; end
            else if (wants_int && bus.ie && m_state != 3) begin
                m_state = 3; m_served = 3; took_int = 1;
            end
            else if (bus.cpu_idle && m_state == 1)           m_state = 1;
            else                                             m_state = 0;
            m_first = 0;
        end
        if (!bus.INT_N) m_pend = 1;
        if (took_int)   m_pend = 0;
        m_pos = (m_pos + 1) % 8;
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge CLOCK);
        @(negedge CLOCK);
        chk(tag, observed(), expected());
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic quiet_inputs();
        bus.WAIT_N = 1; bus.INT_N = 1; bus.ie = 0;
        bus.dma_in_req = 0; bus.dma_out_req = 0;
        bus.cpu_instr_end = 1; bus.cpu_idle = 0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        CLEAR_N = 0;
        tick("reset");
        CLEAR_N = 1;
    endtask

    initial begin
        quiet_inputs();
        CLEAR_N = 0;
        tick("reset0");
        tick("reset1");
        chk("reset_state", observed(), 12'b01_000_0000_000);
        CLEAR_N = 1;

        // Plain fetch/execute alternation
        for (int j = 1; j <= 32; j++) begin
            tick("run");
            chk("run_sc", 12'(bus.SC), ((j / 8) % 2 == 0) ? 12'd1 : 12'd0);
            chk("run_cnt", 12'(bus.cycle_cnt), 12'(j % 8));
        end

        // WAIT_N pause at cnt 3
        ticks(3, "pre_wait");
        bus.WAIT_N = 0;
        for (int j = 0; j < 5; j++) begin
            tick("wait");
            chk("wait_hold", {5'b0, bus.TPA, bus.TPB, bus.cycle_end, bus.cycle_cnt}, 12'h003);
        end
        bus.WAIT_N = 1;
        ticks(4, "resume");
        chk("resume_cend", 12'(bus.cycle_end), 12'd1);
        tick("resume_wrap");
        chk("resume_sc", 12'(bus.SC), 12'd0);

        // Simultaneous DMA requests
        do_reset();
        bus.dma_in_req = 1; bus.dma_out_req = 1;
        ticks(8, "dma1");
        chk("dma_in_first", {bus.SC, bus.grant_dma_in, bus.grant_dma_out, bus.grant_int}, 12'b10_100);
        bus.dma_in_req = 0;
        ticks(8, "dma2");
        chk("dma_out_next", {bus.SC, bus.grant_dma_in, bus.grant_dma_out, bus.grant_int}, 12'b10_010);
        bus.dma_out_req = 0;
        ticks(8, "dma3");
        chk("dma_done", {bus.SC, bus.grant_dma_in, bus.grant_dma_out, bus.grant_int}, 12'b00_000);

        // Interrupt taken, then not repeated back-to-back
        do_reset();
        bus.INT_N = 0; bus.ie = 1;
        ticks(8, "int1");
        chk("int_taken", {bus.SC, bus.grant_dma_in, bus.grant_dma_out, bus.grant_int}, 12'b11_001);
        ticks(8, "int2");
        chk("int_no_repeat", {bus.SC, bus.grant_dma_in, bus.grant_dma_out, bus.grant_int}, 12'b00_000);

        // Interrupt masked
        do_reset();
        bus.INT_N = 0; bus.ie = 0;
        ticks(8, "int_masked");
        chk("int_masked", {bus.SC, bus.grant_int}, 12'b00_0);

        // Idle loop then DMA-out
        do_reset();
        bus.cpu_idle = 1; bus.cpu_instr_end = 0;
        ticks(8, "idle1");
        chk("idle_stay1", 12'(bus.SC), 12'd1);
        ticks(8, "idle2");
        chk("idle_stay2", 12'(bus.SC), 12'd1);
        bus.dma_out_req = 1;
        ticks(8, "idle_dma");
        chk("idle_dma", {bus.SC, bus.grant_dma_out}, 12'b10_1);
        bus.dma_out_req = 0;
        ticks(8, "idle_after");
        chk("idle_after", 12'(bus.SC), 12'd0);

        // Short INT_N pulse during S0
        do_reset();
        bus.ie = 1;
        ticks(10, "pulse_pre");
        bus.INT_N = 0;
        ticks(2, "pulse_low");
        bus.INT_N = 1;
        ticks(4, "pulse_s0");
        chk("pulse_in_s1", 12'(bus.SC), 12'd1);
        ticks(8, "pulse_s1");
`ifdef CDP1802_INT_LATCH_EN
        chk("pulse_taken", {bus.SC, bus.grant_int}, 12'b11_1);
`else
        chk("pulse_ignored", {bus.SC, bus.grant_int}, 12'b00_0);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            CLEAR_N           = ($urandom_range(0, 299) != 0);
            bus.WAIT_N        = ($urandom_range(0, 7) != 0);
            bus.INT_N         = ($urandom_range(0, 3) != 0);
            bus.ie            = 1'($urandom_range(0, 1));
            bus.dma_in_req    = ($urandom_range(0, 5) == 0);
            bus.dma_out_req   = ($urandom_range(0, 5) == 0);
            bus.cpu_instr_end = 1'($urandom_range(0, 1));
            bus.cpu_idle      = ($urandom_range(0, 7) == 0);
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
